// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: push/pop/status bundle between a FIFO and its user
interface param_sync_fifo_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 7
);
  logic             fifo_wr;
  logic             fifo_rd;
  logic [WIDTH-1:0] fifo_din;
  logic             err_clr;
  logic             fifo_rd_vld;
  logic [WIDTH-1:0] fifo_dout;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_mt;
  logic             fifo_amt;
  logic             fifo_afull;
  logic             fifo_full;
  logic             fifo_ovf;
  logic             fifo_udf;
  logic             fifo_conflict;
  logic             fifo_err;
  modport master (
    output fifo_wr, fifo_rd, fifo_din, err_clr,
    input  fifo_rd_vld, fifo_dout, fifo_cnt, fifo_mt, fifo_amt, fifo_afull,
           fifo_full, fifo_ovf, fifo_udf, fifo_conflict, fifo_err
  );
  modport slave (
    input  fifo_wr, fifo_rd, fifo_din, err_clr,
    output fifo_rd_vld, fifo_dout, fifo_cnt, fifo_mt, fifo_amt, fifo_afull,
           fifo_full, fifo_ovf, fifo_udf, fifo_conflict, fifo_err
  );
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with arbitrary depth, occupancy count and sticky error bits
module param_sync_fifo #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 64,
  parameter int AE_LEVEL    = 1,
  parameter int AF_LEVEL    = 1,
  parameter int SINGLE_PORT = 0,
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int AW         = ($clog2(DEPTH) > 0) ? $clog2(DEPTH) : 1
) (
  input logic               clk,
  input logic               reset,
  param_sync_fifo_if.slave  bus
);
  localparam bit SP = SINGLE_PORT != 0;
  if (WIDTH < 1 || DEPTH < 2 || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1 ||
      AF_LEVEL < 0 || AF_LEVEL > DEPTH - 1) begin : g_bad_params
    $error("param_sync_fifo: parameter out of range");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_vld_q, rd_vld_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, conf_q, conf_d;
  logic             full, empty, rd_ok, wr_ok;
  always_comb begin
    full     = cnt_q == CNT_W'(DEPTH);
    empty    = cnt_q == '0;
    rd_ok    = bus.fifo_rd & !empty & !(SP & bus.fifo_wr);
    wr_ok    = bus.fifo_wr & (!full | (rd_ok & !SP));
    wptr_d   = wr_ok ? ((wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1)) : wptr_q;
    rptr_d   = rd_ok ? ((rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1)) : rptr_q;
    cnt_d    = cnt_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    dout_d   = rd_ok ? mem[rptr_q] : dout_q;
    rd_vld_d = rd_ok;
    // a set event in the same cycle as err_clr must win
    ovf_d    = (ovf_q & !bus.err_clr) | (bus.fifo_wr & !wr_ok & full);
    udf_d    = (udf_q & !bus.err_clr) | (bus.fifo_rd & empty);
    conf_d   = SP & ((conf_q & !bus.err_clr) | (bus.fifo_rd & bus.fifo_wr & !empty));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      rd_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      conf_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rd_vld_q <= rd_vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      conf_q   <= conf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem[wptr_q] <= bus.fifo_din;
  end
  assign bus.fifo_rd_vld   = rd_vld_q;
  assign bus.fifo_dout     = dout_q;
  assign bus.fifo_cnt      = cnt_q;
  assign bus.fifo_mt       = empty;
  assign bus.fifo_amt      = cnt_q <= CNT_W'(AE_LEVEL);
  assign bus.fifo_afull    = cnt_q >= CNT_W'(DEPTH - AF_LEVEL);
  assign bus.fifo_full     = full;
  assign bus.fifo_ovf      = ovf_q;
  assign bus.fifo_udf      = udf_q;
  assign bus.fifo_conflict = conf_q;
  assign bus.fifo_err      = ovf_q | udf_q | conf_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_cnt_range: assert (cnt_q <= CNT_W'(DEPTH));
      a_mt_full: assert (!(empty && full));
    end
  end
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed checks of a 2P and a 1P depth-6 FIFO
module tb_param_sync_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  param_sync_fifo_if #(.WIDTH(16), .CNT_W(3)) bus_a ();
  param_sync_fifo_if #(.WIDTH(16), .CNT_W(3)) bus_b ();
  param_sync_fifo #(.WIDTH(16), .DEPTH(6), .AE_LEVEL(1), .AF_LEVEL(1), .SINGLE_PORT(0))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  param_sync_fifo #(.WIDTH(16), .DEPTH(6), .AE_LEVEL(1), .AF_LEVEL(1), .SINGLE_PORT(1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    bus_a.fifo_wr = 0; bus_a.fifo_rd = 0; bus_a.fifo_din = '0; bus_a.err_clr = 0;
    bus_b.fifo_wr = 0; bus_b.fifo_rd = 0; bus_b.fifo_din = '0; bus_b.err_clr = 0;
    tick(); tick();
    reset = 0;
    chk("rst_cnt", 32'(bus_a.fifo_cnt), 0);
    chk("rst_mt", 32'(bus_a.fifo_mt), 1);
    chk("rst_amt", 32'(bus_a.fifo_amt), 1);
    chk("rst_afull", 32'(bus_a.fifo_afull), 0);
    chk("rst_full", 32'(bus_a.fifo_full), 0);
    chk("rst_vld", 32'(bus_a.fifo_rd_vld), 0);
    chk("rst_dout", 32'(bus_a.fifo_dout), 0);
    chk("rst_err", 32'(bus_a.fifo_err), 0);
    // fill 1..6
    for (int i = 1; i <= 6; i++) begin
      bus_a.fifo_wr = 1; bus_a.fifo_din = 16'(i);
      tick();
      chk("fill_cnt", 32'(bus_a.fifo_cnt), 32'(i));
      chk("fill_amt", 32'(bus_a.fifo_amt), 32'(i <= 1));
      chk("fill_afull", 32'(bus_a.fifo_afull), 32'(i >= 5));
      chk("fill_full", 32'(bus_a.fifo_full), 32'(i == 6));
    end
    // overflow while full
    bus_a.fifo_din = 16'hBEEF;
    tick();
    bus_a.fifo_wr = 0;
    chk("ovf_bit", 32'(bus_a.fifo_ovf), 1);
    chk("ovf_err", 32'(bus_a.fifo_err), 1);
    chk("ovf_cnt", 32'(bus_a.fifo_cnt), 6);
    bus_a.err_clr = 1;
    tick();
    bus_a.err_clr = 0;
    chk("clr_ovf", 32'(bus_a.fifo_ovf), 0);
    chk("clr_err", 32'(bus_a.fifo_err), 0);
    // drain
    bus_a.fifo_rd = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("pop_vld", 32'(bus_a.fifo_rd_vld), 1);
      chk("pop_dout", 32'(bus_a.fifo_dout), 32'(i));
      chk("pop_cnt", 32'(bus_a.fifo_cnt), 32'(6 - i));
    end
    bus_a.fifo_rd = 0;
    tick();
    chk("idle_vld", 32'(bus_a.fifo_rd_vld), 0);
    chk("idle_dout_hold", 32'(bus_a.fifo_dout), 6);
    chk("empty_mt", 32'(bus_a.fifo_mt), 1);
    chk("empty_amt", 32'(bus_a.fifo_amt), 1);
    // underflow
    bus_a.fifo_rd = 1;
    tick();
    bus_a.fifo_rd = 0;
    chk("udf_bit", 32'(bus_a.fifo_udf), 1);
    chk("udf_vld", 32'(bus_a.fifo_rd_vld), 0);
    chk("udf_cnt", 32'(bus_a.fifo_cnt), 0);
    bus_a.err_clr = 1;
    tick();
    bus_a.err_clr = 0;
    chk("clr_udf", 32'(bus_a.fifo_udf), 0);
    // full streaming across wraps
    bus_a.fifo_wr = 1;
    for (int k = 0; k < 6; k++) begin
      bus_a.fifo_din = 16'(16'h100 + k);
      tick();
    end
    bus_a.fifo_rd = 1;
    for (int j = 0; j < 20; j++) begin
      bus_a.fifo_din = 16'(16'h106 + j);
      tick();
      chk("strm_dout", 32'(bus_a.fifo_dout), 32'(16'h100 + j));
      chk("strm_cnt", 32'(bus_a.fifo_cnt), 6);
    end
    bus_a.fifo_wr = 0;
    chk("strm_err", 32'(bus_a.fifo_err), 0);
    tick();
    tick();
    chk("pre_rst_cnt", 32'(bus_a.fifo_cnt), 4);
    chk("pre_rst_dout", 32'(bus_a.fifo_dout), 32'h115);
    // reset with a read in flight
    reset = 1;
    tick();
    reset = 0;
    bus_a.fifo_rd = 0;
    chk("mrst_vld", 32'(bus_a.fifo_rd_vld), 0);
    chk("mrst_cnt", 32'(bus_a.fifo_cnt), 0);
    chk("mrst_mt", 32'(bus_a.fifo_mt), 1);
    chk("mrst_dout", 32'(bus_a.fifo_dout), 0);
    chk("mrst_err", 32'(bus_a.fifo_err), 0);
    bus_a.fifo_wr = 1; bus_a.fifo_din = 16'h1234;
    tick();
    bus_a.fifo_wr = 0; bus_a.fifo_rd = 1;
    tick();
    bus_a.fifo_rd = 0;
    chk("post_vld", 32'(bus_a.fifo_rd_vld), 1);
    chk("post_dout", 32'(bus_a.fifo_dout), 32'h1234);
    // single-port instance
    bus_b.fifo_wr = 1;
    for (int k = 1; k <= 3; k++) begin
      bus_b.fifo_din = 16'(16'hA0 + k);
      tick();
    end
    chk("sp_cnt3", 32'(bus_b.fifo_cnt), 3);
    bus_b.fifo_rd = 1; bus_b.fifo_din = 16'hA4;
    tick();
    chk("sp_cnt4", 32'(bus_b.fifo_cnt), 4);
    chk("sp_conf", 32'(bus_b.fifo_conflict), 1);
    chk("sp_vld", 32'(bus_b.fifo_rd_vld), 0);
    chk("sp_err", 32'(bus_b.fifo_err), 1);
    bus_b.err_clr = 1; bus_b.fifo_din = 16'hA5;
    tick();
    chk("sp_setwins", 32'(bus_b.fifo_conflict), 1);
    chk("sp_cnt5", 32'(bus_b.fifo_cnt), 5);
    bus_b.fifo_wr = 0; bus_b.fifo_rd = 0;
    tick();
    bus_b.err_clr = 0;
    chk("sp_clr", 32'(bus_b.fifo_conflict), 0);
    bus_b.fifo_rd = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sp_dout", 32'(bus_b.fifo_dout), 32'(16'hA0 + k));
    end
    bus_b.fifo_rd = 0;
    tick();
    chk("sp_mt", 32'(bus_b.fifo_mt), 1);
    chk("sp_noerr", 32'(bus_b.fifo_err), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
